// File: rtl/mips_cpu_muldiv_sequencer_if.sv
// HI/LO unit bus: request side from the pipeline, status and results back.
//
// Handshake: start is the valid of a request (op, rs, rt) and !busy is its
// ready. A request is taken on the rising clk edge where start=1 and busy=0.
// While start=1 and busy=1, stall=1 and the requester must hold start, op,
// rs and rt unchanged until the request is taken.
interface mips_cpu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, rs, rt,
    input  stall, busy, mf_data, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, rs, rt,
    output stall, busy, mf_data, hi, lo, dbg_state
  );
endinterface

// File: rtl/mips_cpu_muldiv_sequencer.sv
// Multi-cycle HI/LO unit: MULT/MULTU/DIV/DIVU run one bit per cycle through a
// single shared adder/subtractor on unsigned magnitudes. Signs are applied in
// FIX, where HI and LO are written together.
module mips_cpu_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                        clk,
  input logic                        reset,
  mips_cpu_muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  // acc: product high half, or partial remainder
  logic [WIDTH-1:0] acc;
  // qreg: multiplier being shifted out, or quotient being shifted in
  logic [WIDTH-1:0] qreg;
  // opb: multiplicand, or divisor
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] add_a;
  logic [WIDTH+1:0] add_b;
  logic [WIDTH+1:0] add_res;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;

  // Decode of the request and operand magnitudes (signed ops: MULT=011, DIV=010).
  always_comb begin
    accept    = bus.start & ~busy_q;
    op_signed = bus.op[1];
    op_div    = ~bus.op[0];
    mag_a     = (op_signed & bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
    mag_b     = (op_signed & bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;
  end

  // Shared datapath: add for shift-add multiply, subtract for restoring divide.
  // Two guard bits make the top bit of the result a clean borrow flag.
  always_comb begin
    div_shift = {acc, qreg[WIDTH-1]};
    add_a     = is_div ? {1'b0, div_shift} : {2'b00, acc};
    add_b     = is_div ? ~{2'b00, opb} : (qreg[0] ? {2'b00, opb} : '0);
    add_res   = add_a + add_b + {{(WIDTH+1){1'b0}}, is_div};
    div_ok    = ~add_res[WIDTH+1];
    prod      = {acc, qreg};
  end

  // Sequencer FSM, iteration registers and the HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc    <= '0;
      qreg   <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              3'b100: hi_q <= bus.rs;
              3'b101: lo_q <= bus.rs;
              3'b110, 3'b111: ;
              default: begin
                acc    <= '0;
                qreg   <= op_div ? mag_a : mag_b;
                opb    <= op_div ? mag_b : mag_a;
                is_div <= op_div;
                // A zero divisor leaves the all-ones quotient unsigned.
                neg_q  <= op_signed & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1])
                          & ~(op_div & (bus.rt == '0));
                neg_r  <= op_signed & bus.rs[WIDTH-1];
                cnt    <= CW'(WIDTH - 1);
                state  <= CALC;
                busy_q <= 1'b1;
              end
            endcase
          end
        end
        CALC: begin
          if (is_div) begin
            acc  <= div_ok ? add_res[WIDTH-1:0] : div_shift[WIDTH-1:0];
            qreg <= {qreg[WIDTH-2:0], div_ok};
          end else begin
            acc  <= add_res[WIDTH:1];
            qreg <= {add_res[0], qreg[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo_q <= neg_q ? -qreg : qreg;
            hi_q <= neg_r ? -acc : acc;
          end else begin
            {hi_q, lo_q} <= neg_q ? -prod : prod;
          end
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Status and read-back outputs.
  always_comb begin
    bus.busy      = busy_q;
    bus.stall     = bus.start & busy_q;
    bus.mf_data   = (bus.op == 3'b110) ? hi_q : lo_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.dbg_state = state;
  end
endmodule

// File: tb/tb_mips_cpu_muldiv_sequencer.sv
// Bench for the HI/LO unit: directed cases with literal results, then random
// traffic checked every cycle against an arithmetic model of HI/LO.
module tb_mips_cpu_muldiv_sequencer;
  localparam int W = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  mips_cpu_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: architectural HI/LO, busy countdown, pending results
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  int             m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] mdl(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [2*W-1:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    res = '0;
    case (op)
      3'b011: res = sa * sb;
      3'b001: res = ua * ub;
      3'b010: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'b000: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model update on each clock edge or reset
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_cnt = 0;
      exp_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (bus.start) begin
      case (bus.op)
        3'b100: m_hi = bus.rs;
        3'b101: m_lo = bus.rs;
        3'b110, 3'b111: ;
        default: begin
          exp_q.push_back(mdl(bus.op, bus.rs, bus.rt));
          m_cnt = W + 1;
        end
      endcase
    end
  end

  // Per-cycle compare, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("busy", 64'(bus.busy), 64'(m_cnt > 0));
      chk("stall", 64'(bus.stall), 64'(bus.start && m_cnt > 0));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      if (bus.start && m_cnt == 0)
        chk("mf_data", 64'(bus.mf_data), 64'((bus.op == 3'b110) ? m_hi : m_lo));
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs = $urandom; bus.rt = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_idle"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    issue(op, a, b);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 64'(n), 64'(W + 1));
    chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({name, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.rs = '0; bus.rt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(bus.hi), 64'(0));
    chk("reset_lo", 64'(bus.lo), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));

    // Reset in the middle of a multiply
    issue(3'b100, 32'h55, 32'h0);
    issue(3'b011, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_hi", 64'(bus.hi), 64'(0));
    chk("rst_mid_lo", 64'(bus.lo), 64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_late_hi", 64'(bus.hi), 64'(0));
    chk("rst_late_lo", 64'(bus.lo), 64'(0));

    // Directed arithmetic cases
    run_op("mult_neg", 3'b011, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'b001, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'b000, 32'h7, 32'h2, 32'h1, 32'h3);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_zero", 3'b000, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
    run_op("div_zero_neg", 3'b010, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // MFLO held behind a multiply
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b011; bus.rs = 32'd5; bus.rt = 32'd6;
    @(posedge clk); #1;
    bus.op = 3'b111; bus.rs = $urandom; bus.rt = $urandom;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      chk("mflo_stall_busy", 64'(bus.stall), 64'(1));
      n++;
      @(negedge clk);
    end
    chk("mflo_wait", 64'(n), 64'(W + 1));
    chk("mflo_stall_free", 64'(bus.stall), 64'(0));
    chk("mflo_data", 64'(bus.mf_data), 64'(30));
    @(posedge clk); #1 bus.start = 1'b0;

    // MTHI then MFHI back to back
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b100; bus.rs = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.op = 3'b110; bus.rs = $urandom;
    @(negedge clk);
    chk("mfhi_data", 64'(bus.mf_data), 64'(32'hDEADBEEF));
    chk("mfhi_busy", 64'(bus.busy), 64'(0));
    chk("mfhi_stall", 64'(bus.stall), 64'(0));
    @(posedge clk); #1 bus.start = 1'b0;

    // Random traffic, including stalled retries and rare async resets
    repeat (3000) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 2) != 0);
      bus.op = 3'($urandom_range(0, 7));
      bus.rs = rnd();
      bus.rt = rnd();
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle("final");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
